// File: rtl/wb_select.sv
// Writeback select stage: picks one of NSRC 32-bit sources, extracts and extends
// byte/half loads on the memory source, and holds the result in a one-entry output register.
module wb_select #(
  parameter int NSRC       = 4,
  parameter int MEM_SRC    = 0,
  parameter int BIG_ENDIAN = 1,
  parameter int SELW       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*NSRC-1:0]   src_data,
  input  logic [SELW-1:0]      src_sel,
  input  logic [1:0]           ld_size,
  input  logic                 ld_signed,
  input  logic [1:0]           byte_off,
  input  logic [4:0]           rd_addr,
  input  logic                 rd_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          wb_data,
  output logic [4:0]           wb_addr,
  output logic                 wb_we,
  output logic                 err
);

  logic [31:0] sel_word;
  logic        sel_hit;
  logic        is_mem;
  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_word;
  logic        fault;
  logic [31:0] next_data;
  logic        accept;

  // sel_hit stays low for indices beyond NSRC, which makes them a fault.
  always_comb begin
    sel_word = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_sel == SELW'(k)) begin
        sel_word = src_data[32*k +: 32];
        sel_hit  = 1'b1;
      end
    end
  end

  assign is_mem    = (src_sel == SELW'(MEM_SRC));
  assign byte_lane = (BIG_ENDIAN != 0) ? ~byte_off : byte_off;
  assign half_hi   = (BIG_ENDIAN != 0) ? ~byte_off[1] : byte_off[1];
  assign ld_half   = half_hi ? sel_word[31:16] : sel_word[15:0];

  always_comb begin
    case (byte_lane)
      2'd0:    ld_byte = sel_word[7:0];
      2'd1:    ld_byte = sel_word[15:8];
      2'd2:    ld_byte = sel_word[23:16];
      default: ld_byte = sel_word[31:24];
    endcase
  end

  always_comb begin
    case (ld_size)
      2'b00:   load_word = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   load_word = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: load_word = sel_word;
    endcase
  end

  // Misaligned half/word loads and out-of-range selects are faults; byte loads never are.
  assign fault = !sel_hit ||
                 (is_mem && ((ld_size == 2'b01 && byte_off[0]) ||
                             (ld_size[1] && byte_off != 2'b00)));

  assign next_data = fault ? 32'd0 : (is_mem ? load_word : sel_word);

  // Handshake: a side transfers on a rising edge when its valid and ready are both high;
  // valid never depends on ready, and an offered output holds until it is taken.
  assign in_ready = !reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      wb_data   <= '0;
      wb_addr   <= '0;
      wb_we     <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        wb_data   <= next_data;
        wb_addr   <= rd_addr;
        wb_we     <= rd_we && (rd_addr != 5'd0) && !fault;
        if (fault) begin
          err <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        wb_we     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_select.sv
// Bench for wb_select: big- and little-endian instances share stimulus and are checked
// every cycle against a queue model, plus literal expectations for the key vectors.
module tb_wb_select;

  localparam int NSRC    = 3;
  localparam int SELW    = 2;
  localparam int MEM_SRC = 0;
  localparam int EW      = 70;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             in_valid;
  logic [32*NSRC-1:0] src_data;
  logic [SELW-1:0]  src_sel;
  logic [1:0]       ld_size;
  logic             ld_signed;
  logic [1:0]       byte_off;
  logic [4:0]       rd_addr;
  logic             rd_we;
  logic             out_ready;

  logic        in_ready, out_valid, wb_we, err;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        le_in_ready, le_out_valid, le_wb_we, le_err;
  logic [31:0] le_wb_data;
  logic [4:0]  le_wb_addr;

  wb_select #(.NSRC(NSRC), .MEM_SRC(MEM_SRC), .BIG_ENDIAN(1), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_sel(src_sel), .ld_size(ld_size), .ld_signed(ld_signed),
    .byte_off(byte_off), .rd_addr(rd_addr), .rd_we(rd_we), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we), .err(err)
  );

  wb_select #(.NSRC(NSRC), .MEM_SRC(MEM_SRC), .BIG_ENDIAN(0), .SELW(SELW)) dut_le (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(le_in_ready),
    .src_data(src_data), .src_sel(src_sel), .ld_size(ld_size), .ld_signed(ld_signed),
    .byte_off(byte_off), .rd_addr(rd_addr), .rd_we(rd_we), .out_valid(le_out_valid),
    .out_ready(out_ready), .wb_data(le_wb_data), .wb_addr(le_wb_addr), .wb_we(le_wb_we),
    .err(le_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_fault(input logic [SELW-1:0] sel, input logic [1:0] size,
                                       input logic [1:0] off);
    if (int'(sel) >= NSRC) return 1'b1;
    if (int'(sel) == MEM_SRC) begin
      if (size == 2'b01) return off[0];
      if (size[1]) return (off != 2'b00);
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_extend(input logic [31:0] w, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] off,
                                               input bit be);
    int          sh;
    logic [31:0] v;
    if (size[1]) return w;
    if (size == 2'b00) begin
      sh = be ? 8 * (3 - int'(off)) : 8 * int'(off);
      v  = (w >> sh) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      sh = (be ? (off[1] == 1'b0) : (off[1] == 1'b1)) ? 16 : 0;
      v  = (w >> sh) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_data(input logic [32*NSRC-1:0] src,
                                             input logic [SELW-1:0] sel, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off, input bit be);
    logic [31:0] w;
    if (model_fault(sel, size, off)) return 32'd0;
    w = src[32*int'(sel) +: 32];
    if (int'(sel) == MEM_SRC) return model_extend(w, size, sgn, off, be);
    return w;
  endfunction

  // Each entry: {be_data, le_data, addr, we}; the head is what the output register must show.
  logic [EW-1:0] exp_q[$];
  logic          m_err     = 1'b0;
  logic          rst_seen  = 1'b0;
  logic          started   = 1'b0;
  logic          m_acc;
  logic          m_f;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_err    = 1'b0;
      rst_seen = 1'b1;
      started  = 1'b1;
    end else if (started) begin
      rst_seen = 1'b0;
      m_acc    = in_valid && (exp_q.size() == 0 || out_ready);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (m_acc) begin
        m_f = model_fault(src_sel, ld_size, byte_off);
        exp_q.push_back({model_data(src_data, src_sel, ld_size, ld_signed, byte_off, 1'b1),
                         model_data(src_data, src_sel, ld_size, ld_signed, byte_off, 1'b0),
                         rd_addr, rd_we && (rd_addr != 5'd0) && !m_f});
        if (m_f) m_err = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [EW-1:0] cur;
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(!reset && (exp_q.size() == 0 || out_ready)));
      check("le_in_ready", 32'(le_in_ready), 32'(!reset && (exp_q.size() == 0 || out_ready)));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("le_out_valid", 32'(le_out_valid), 32'(exp_q.size() != 0));
      check("err", 32'(err), 32'(m_err));
      check("le_err", 32'(le_err), 32'(m_err));
      if (exp_q.size() != 0) begin
        cur = exp_q[0];
        check("wb_data", wb_data, cur[69:38]);
        check("le_wb_data", le_wb_data, cur[37:6]);
        check("wb_addr", 32'(wb_addr), 32'(cur[5:1]));
        check("le_wb_addr", 32'(le_wb_addr), 32'(cur[5:1]));
        check("wb_we", 32'(wb_we), 32'(cur[0]));
        check("le_wb_we", 32'(le_wb_we), 32'(cur[0]));
      end
      if (rst_seen) begin
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input vec_t v);
    src_data  = {v.s2, v.s1, v.s0};
    src_sel   = v.sel;
    ld_size   = v.size;
    ld_signed = v.sgn;
    byte_off  = v.off;
    rd_addr   = v.rd;
    rd_we     = v.we;
  endtask

  // Offers one transfer and returns #1 after the edge that accepted it.
  task automatic drive(input vec_t v);
    logic rdy;
    set_inputs(v);
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      if (n == 59) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] size, input logic sgn,
                              input logic [1:0] off, input logic [4:0] rd, input logic we,
                              input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    vec_t v;
    v.sel = sel; v.size = size; v.sgn = sgn; v.off = off; v.rd = rd; v.we = we;
    v.s0 = s0; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  vec_t        tbl[8];
  logic [23:0] rpat = 24'b1111_0110_1001_1100_0101_0011;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_inputs(mk(2'd0, 2'd2, 1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Model pins against hand-computed values.
    check("m_byte_off0_s", model_extend(32'h80FF7F01, 2'b00, 1'b1, 2'd0, 1'b1), 32'hFFFF_FF80);
    check("m_byte_off3_u", model_extend(32'h80FF7F01, 2'b00, 1'b0, 2'd3, 1'b1), 32'h0000_0001);
    check("m_half_off2_s", model_extend(32'h80FF7F01, 2'b01, 1'b1, 2'd2, 1'b1), 32'h0000_7F01);
    check("m_le_half_off2", model_extend(32'h80FF7F01, 2'b01, 1'b1, 2'd2, 1'b0), 32'hFFFF_80FF);

    // Plain pass-through of source 1.
    drive(mk(2'd1, 2'd2, 1'b0, 2'd0, 5'd5, 1'b1, 32'h0, 32'h12345678, 32'h0));
    @(negedge clk);
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_data", wb_data, 32'h12345678);
    check("pass_addr", 32'(wb_addr), 32'd5);
    check("pass_we", 32'(wb_we), 32'd1);
    @(posedge clk); #1;

    // Byte/half extraction on the memory source.
    drive(mk(2'd0, 2'b00, 1'b1, 2'd0, 5'd3, 1'b1, 32'h80FF7F01, 32'h0, 32'h0));
    @(negedge clk);
    check("byte_off0_s", wb_data, 32'hFFFF_FF80);
    @(posedge clk); #1;
    drive(mk(2'd0, 2'b00, 1'b0, 2'd3, 5'd3, 1'b1, 32'h80FF7F01, 32'h0, 32'h0));
    @(negedge clk);
    check("byte_off3_u", wb_data, 32'h0000_0001);
    @(posedge clk); #1;
    drive(mk(2'd0, 2'b01, 1'b1, 2'd2, 5'd3, 1'b1, 32'h80FF7F01, 32'h0, 32'h0));
    @(negedge clk);
    check("half_off2_s", wb_data, 32'h0000_7F01);
    check("le_half_off2_s", le_wb_data, 32'hFFFF_80FF);
    @(posedge clk); #1;

    // Stall with a second transfer held, then drain back-to-back.
    out_ready = 1'b0;
    drive(mk(2'd2, 2'd2, 1'b0, 2'd0, 5'd10, 1'b1, 32'h0, 32'h0, 32'hAAAA_0001));
    fork
      drive(mk(2'd1, 2'd2, 1'b0, 2'd0, 5'd11, 1'b1, 32'h0, 32'hBBBB_0002, 32'h0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_data", wb_data, 32'hAAAA_0001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drive(mk(2'd0, 2'b00, 1'b0, 2'd1, 5'd12, 1'b1, 32'h12F45678, 32'h0, 32'h0));
    drive(mk(2'd0, 2'b01, 1'b1, 2'd0, 5'd13, 1'b0, 32'h8001_7FFE, 32'h0, 32'h0));
    drive(mk(2'd1, 2'd3, 1'b0, 2'd0, 5'd31, 1'b1, 32'h0, 32'h5555_AAAA, 32'h0));
    idle(3);

    // Mixed vectors under an irregular consumer.
    tbl[0] = mk(2'd2, 2'd2, 1'b0, 2'd0, 5'd9,  1'b1, 32'h0, 32'h0, 32'hCAFE_BABE);
    tbl[1] = mk(2'd0, 2'b00, 1'b1, 2'd1, 5'd1, 1'b1, 32'h12F4_5678, 32'h0, 32'h0);
    tbl[2] = mk(2'd0, 2'b00, 1'b0, 2'd2, 5'd2, 1'b1, 32'h12F4_D678, 32'h0, 32'h0);
    tbl[3] = mk(2'd0, 2'b01, 1'b1, 2'd0, 5'd4, 1'b1, 32'h8001_7FFE, 32'h0, 32'h0);
    tbl[4] = mk(2'd0, 2'b01, 1'b0, 2'd2, 5'd6, 1'b1, 32'h8001_FFFE, 32'h0, 32'h0);
    tbl[5] = mk(2'd0, 2'd2, 1'b0, 2'd0, 5'd8, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0);
    tbl[6] = mk(2'd1, 2'b00, 1'b1, 2'd3, 5'd14, 1'b1, 32'h0, 32'h0000_0080, 32'h0);
    tbl[7] = mk(2'd0, 2'b00, 1'b1, 2'd3, 5'd15, 1'b0, 32'h0000_0080, 32'h0, 32'h0);
    fork
      begin
        for (int j = 0; j < 24; j++) begin
          out_ready = rpat[j];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) drive(tbl[i]);
      end
    join
    idle(3);

    // Faults: misaligned word sets the sticky error.
    drive(mk(2'd0, 2'd2, 1'b0, 2'd1, 5'd7, 1'b1, 32'h1234_5678, 32'h0, 32'h0));
    @(negedge clk);
    check("fault_err", 32'(err), 32'd1);
    check("fault_we", 32'(wb_we), 32'd0);
    check("fault_data", wb_data, 32'd0);
    @(posedge clk); #1;
    drive(mk(2'd1, 2'd2, 1'b0, 2'd0, 5'd7, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h0));
    drive(mk(2'd3, 2'd2, 1'b0, 2'd0, 5'd7, 1'b1, 32'h1, 32'h2, 32'h3));
    drive(mk(2'd0, 2'b01, 1'b0, 2'd1, 5'd7, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0));
    drive(mk(2'd2, 2'd2, 1'b0, 2'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h7777_7777));
    @(negedge clk);
    check("zero_rd_we", 32'(wb_we), 32'd0);
    check("err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;

    // Reset while a stalled output is held and a new input is offered.
    out_ready = 1'b0;
    drive(mk(2'd1, 2'd2, 1'b0, 2'd0, 5'd20, 1'b1, 32'h0, 32'h3333_4444, 32'h0));
    set_inputs(mk(2'd2, 2'd2, 1'b0, 2'd0, 5'd21, 1'b1, 32'h0, 32'h0, 32'h9999_0000));
    in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready_first", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_select.md
WB_SELECT -- requirements
Module: wb_select

Interface
REQ-001 Parameter NSRC, default 4: number of writeback sources, legal range 2..8.
REQ-002 Parameter MEM_SRC, default 0: index of the source that carries raw load data and receives byte/half extraction.
REQ-003 Parameter BIG_ENDIAN, default 1: 1 = byte_off 0 selects bits [31:24]; 0 = byte_off 0 selects bits [7:0].
REQ-004 Parameter SELW, default 2: src_sel width; SHALL satisfy 2^SELW >= NSRC.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  an input transfer is offered.
REQ-009 in_ready  out  1  the block accepts the input this cycle.
REQ-010 src_data  in  32*NSRC  packed sources; source k occupies bits [32k+31:32k].
REQ-011 src_sel  in  SELW  index of the source to write back.
REQ-012 ld_size  in  2  00 byte, 01 half, 10/11 word; used only when src_sel==MEM_SRC.
REQ-013 ld_signed  in  1  1 = sign-extend, 0 = zero-extend the extracted byte/half.
REQ-014 byte_off  in  2  low address bits of the load.
REQ-015 rd_addr  in  5  destination register.
REQ-016 rd_we  in  1  register write requested.
REQ-017 out_valid  out  1  wb_* outputs hold a valid transfer.
REQ-018 out_ready  in  1  the consumer accepts the output this cycle.
REQ-019 wb_data  out  32  registered writeback data.
REQ-020 wb_addr  out  5  registered destination register.
REQ-021 wb_we  out  1  registered write enable, qualified by out_valid.
REQ-022 err  out  1  sticky error flag.

Function
REQ-023 The block SHALL be a one-entry registered stage: in_ready = !reset && (!out_valid || out_ready).
REQ-024 A transfer SHALL be accepted on a rising edge when in_valid && in_ready, and SHALL appear on wb_* with out_valid=1 on the next cycle (latency 1).
REQ-025 When out_valid && !out_ready, wb_data, wb_addr, wb_we and out_valid SHALL hold unchanged.
REQ-026 When out_valid && out_ready && !in_valid, out_valid SHALL drop to 0 on the next edge.
REQ-027 A simultaneous output drain and input accept SHALL replace the output register in the same edge, with no bubble.
REQ-028 When src_sel != MEM_SRC, wb_data SHALL equal the selected 32-bit source unchanged.
REQ-029 When src_sel == MEM_SRC and ld_size=00, the byte at byte_off SHALL be extended to 32 bits (per endianness) according to ld_signed.
REQ-030 When src_sel == MEM_SRC and ld_size=01, the half at byte_off[1] SHALL be extended (per endianness); big-endian byte_off[1]=0 selects [31:16].
REQ-031 When src_sel == MEM_SRC and ld_size=1x, wb_data SHALL equal the whole word.
REQ-032 Fault conditions are: src_sel >= NSRC; or src_sel==MEM_SRC with half and byte_off[0]=1; or word and byte_off!=0.
REQ-033 On accepting a faulty transfer, err SHALL set and remain set until reset.
REQ-034 For a faulty transfer, wb_we SHALL be 0 and wb_data SHALL be 0.
REQ-035 wb_we SHALL be registered as rd_we && (rd_addr!=0) && !fault, so that $zero is never written.

Reset
REQ-036 On reset: out_valid=0, wb_data=0, wb_addr=0, wb_we=0, err=0, in_ready=0.
REQ-037 A transfer held or offered during reset SHALL be discarded.
REQ-038 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-039 BE, src1=0x12345678, sel=1, rd=5, we=1, out_ready=1 -> next cycle out_valid=1, wb_data=0x12345678, wb_addr=5, wb_we=1.
REQ-040 BE, src0=0x80FF7F01, sel=0: (a) byte, off=0, signed -> 0xFFFFFF80; (b) byte, off=3, unsigned -> 0x00000001; (c) half, off=2, signed -> 0x00007F01.
REQ-041 BIG_ENDIAN=0, src0=0x80FF7F01, half, off=2, signed -> 0xFFFF80FF.
REQ-042 out_ready=0 for 3 cycles with in_valid held -> wb_* stable and in_ready=0; then out_ready=1 -> back-to-back transfers, no loss or duplication.
REQ-043 Word load with off=1, rd=7, we=1 -> err=1, wb_we=0, wb_data=0; err stays 1 across later good transfers until reset; rd=0 with we=1 -> wb_we=0.
REQ-044 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and all outputs 0.
